// File: rtl/pxs_vga_sync_gen_pkg.sv
// Shared definitions for the Pxs raster timing source: stream word layout and
// default 640x480@60 timing.
package pxs_vga_sync_gen_pkg;
  localparam int STR_W = 23;
  localparam int CW    = 10;

  localparam int H_ACT_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_ACT_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;
  localparam int POL_D    = 0;

  // Bit layout of the VGA_SCA stream: HS[22] VS[21] XC[20:11] YC[10:1] Active[0]
  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CW-1:0] xc;
    logic [CW-1:0] yc;
    logic          active;
  } vga_sca_t;

  function automatic int axis_tot(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
endpackage

// File: rtl/pxs_timing_axis.sv
// One raster axis: mod-TOT position counter with wrap strobe plus combinational
// sync/active decode of the current count.
module pxs_timing_axis
  import pxs_vga_sync_gen_pkg::*;
#(
  parameter int ACT  = H_ACT_D,
  parameter int FP   = H_FP_D,
  parameter int SYNC = H_SYNC_D,
  parameter int BP   = H_BP_D,
  parameter int POL  = POL_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          active_o
);
  localparam int TOT = axis_tot(ACT, FP, SYNC, BP);

  if (TOT > 1024 || TOT < 1) begin : g_bad_tot
    $error("pxs_timing_axis: total %0d outside 1..1024", TOT);
  end

  localparam logic [CW-1:0] LAST  = CW'(TOT - 1);
  localparam logic          POL_L = 1'(POL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cnt32;
  logic          last;

  assign cnt32 = 32'(cnt_q);
  assign last  = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Decode uses 32-bit compares so SYNC end may equal 1024 without truncation
  assign cnt_o    = cnt_q;
  assign wrap_o   = inc && last;
  assign active_o = (cnt32 < 32'(ACT));
  assign sync_o   = ((cnt32 >= 32'(ACT + FP)) && (cnt32 < 32'(ACT + FP + SYNC))) ? POL_L : ~POL_L;
endmodule

// File: rtl/pxs_vga_sync_gen.sv
// Raster timing source: cascaded pixel/line axes with a registered VGA_SCA word
// and line/frame start pulses, all from one counter snapshot.
module pxs_vga_sync_gen
  import pxs_vga_sync_gen_pkg::*;
#(
  parameter int H_ACT  = H_ACT_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_ACT  = V_ACT_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter int HS_POL = POL_D,
  parameter int VS_POL = POL_D
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic             px_en,
  output logic [STR_W-1:0] VGA_SCA_Str_o,
  output logic             frame_start_o,
  output logic             line_start_o
);
  localparam vga_sca_t RST_WORD = '{hs: ~1'(HS_POL), vs: ~1'(VS_POL), xc: '0, yc: '0, active: 1'b0};

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_sync, v_sync, h_act, v_act;

  pxs_timing_axis #(.ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h_axis (
    .clk(px_clk), .rst_n(rst_n), .inc(px_en),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .sync_o(h_sync), .active_o(h_act)
  );

  pxs_timing_axis #(.ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v_axis (
    .clk(px_clk), .rst_n(rst_n), .inc(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .sync_o(v_sync), .active_o(v_act)
  );

  vga_sca_t str_q, str_d;
  logic     fs_q, fs_d, ls_q, ls_d;
  logic     unused_v_wrap;

  assign unused_v_wrap = v_wrap;

  // Pulses default low so a held word never repeats a start pulse
  always_comb begin
    str_d = str_q;
    fs_d  = 1'b0;
    ls_d  = 1'b0;
    if (px_en) begin
      str_d.hs     = h_sync;
      str_d.vs     = v_sync;
      str_d.xc     = h_cnt;
      str_d.yc     = v_cnt;
      str_d.active = h_act && v_act;
      ls_d         = (h_cnt == '0);
      fs_d         = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      str_q <= RST_WORD;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      str_q <= str_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
    end
  end

  assign VGA_SCA_Str_o = str_q;
  assign frame_start_o = fs_q;
  assign line_start_o  = ls_q;
endmodule

// File: tb/tb_pxs_vga_sync_gen.sv
// Directed bench: small 14x7 raster checked word by word against hand-derived
// timing, plus a short run of the default 640x480 timing.
module tb_pxs_vga_sync_gen;
  import pxs_vga_sync_gen_pkg::*;

  logic             px_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             px_en  = 1'b0;
  logic             en2    = 1'b0;
  logic [STR_W-1:0] str, str2;
  logic             fs, ls, fs2, ls2;

  int n_chk  = 0;
  int n_fail = 0;
  int ex = 0, ey = 0;
  int px = 0, py = 0;

  always #5 px_clk = ~px_clk;

  pxs_vga_sync_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .px_clk(px_clk), .rst_n(rst_n), .px_en(px_en),
    .VGA_SCA_Str_o(str), .frame_start_o(fs), .line_start_o(ls)
  );

  pxs_vga_sync_gen dut_big (
    .px_clk(px_clk), .rst_n(rst_n), .px_en(en2),
    .VGA_SCA_Str_o(str2), .frame_start_o(fs2), .line_start_o(ls2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Small raster: H 8/2/2/2 (sync at x 10,11), V 4/1/1/1 (sync at y 5), active-low syncs
  function automatic logic [STR_W-1:0] exp_w(input int x, input int y);
    vga_sca_t w;
    w.hs     = (x == 10 || x == 11) ? 1'b0 : 1'b1;
    w.vs     = (y == 5) ? 1'b0 : 1'b1;
    w.xc     = CW'(x);
    w.yc     = CW'(y);
    w.active = (x < 8) && (y < 4);
    return w;
  endfunction

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic step_chk();
    tick();
    chk("word", 32'(str), 32'(exp_w(ex, ey)));
    chk("line_start", 32'(ls), 32'(ex == 0));
    chk("frame_start", 32'(fs), 32'(ex == 0 && ey == 0));
    px = ex;
    py = ey;
    if (ex == 13) begin
      ex = 0;
      ey = (ey == 6) ? 0 : ey + 1;
    end else begin
      ex++;
    end
  endtask

  task automatic chk_reset_word(input string tag);
    chk({tag, "_word"}, 32'(str), 32'({1'b1, 1'b1, 10'd0, 10'd0, 1'b0}));
    chk({tag, "_ls"}, 32'(ls), 32'd0);
    chk({tag, "_fs"}, 32'(fs), 32'd0);
  endtask

  initial begin
    int act_n, hs_n, vs_n, fs_n, ls_n;
    vga_sca_t w;

    // 1: reset, including reset overriding px_en
    tick(); tick();
    chk_reset_word("rst");
    px_en = 1'b1;
    tick();
    chk_reset_word("rst_en");
    rst_n = 1'b1;
    tick();
    chk("first_word", 32'(str), 32'({1'b1, 1'b1, 10'd0, 10'd0, 1'b1}));
    chk("first_ls", 32'(ls), 32'd1);
    chk("first_fs", 32'(fs), 32'd1);
    ex = 1;

    // 2/3: one frame window (1,0) .. (0,0) holds exactly one frame start
    act_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int i = 0; i < 98; i++) begin
      step_chk();
      w = str;
      act_n += int'(w.active);
      hs_n  += int'(!w.hs);
      vs_n  += int'(!w.vs);
      fs_n  += int'(fs);
    end
    chk("frame_active_cnt", 32'(act_n), 32'd32);
    chk("frame_hs_low_cnt", 32'(hs_n), 32'd14);
    chk("frame_vs_low_cnt", 32'(vs_n), 32'd14);
    chk("frame_start_cnt", 32'(fs_n), 32'd1);
    chk("wrap_pos", 32'({px[15:0], py[15:0]}), 32'h0000_0000);
    for (int i = 0; i < 97; i++) step_chk();

    // 4: hold right after a line-start word; word held, pulses low, no skip
    for (int i = 0; i < 20 && ex != 0; i++) step_chk();
    step_chk();
    px_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_word", 32'(str), 32'(exp_w(px, py)));
      chk("hold_ls", 32'(ls), 32'd0);
      chk("hold_fs", 32'(fs), 32'd0);
    end
    px_en = 1'b1;
    for (int i = 0; i < 3; i++) step_chk();

    // 5: reset mid-frame at (9,3)
    for (int i = 0; i < 200 && !(px == 9 && py == 3); i++) step_chk();
    chk("reached_9_3", 32'({px[15:0], py[15:0]}), 32'h0009_0003);
    rst_n = 1'b0;
    tick();
    chk_reset_word("midrst");
    rst_n = 1'b1;
    ex = 0; ey = 0;
    for (int i = 0; i < 16; i++) step_chk();

    // 6: default 640x480 timing over three lines
    px_en = 1'b0;
    en2   = 1'b1;
    act_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; ls_n = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      w = str2;
      act_n += int'(w.active);
      hs_n  += int'(!w.hs);
      vs_n  += int'(!w.vs);
      fs_n  += int'(fs2);
      ls_n  += int'(ls2);
      if (i == 799) chk("big_last_x", 32'({w.xc, 6'd0, w.yc}), 32'({10'd799, 6'd0, 10'd0}));
      if (i == 800) chk("big_wrap", 32'({w.xc, 6'd0, w.yc}), 32'({10'd0, 6'd0, 10'd1}));
    end
    chk("big_active_cnt", 32'(act_n), 32'd1920);
    chk("big_hs_low_cnt", 32'(hs_n), 32'd288);
    chk("big_vs_low_cnt", 32'(vs_n), 32'd0);
    chk("big_fs_cnt", 32'(fs_n), 32'd1);
    chk("big_ls_cnt", 32'(ls_n), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
